ctrl_unit_mc: RTL and testbench

//  Multicycle Moore control FSM: the producer end of the datapath select/enable buses. Drives alu_src_b[1:0] (00=B reg, 01=const 4, 10=offset<<2, 11=sign-ext imm) and alu_src_a.

---
 rtl/ctrl_unit_mc.sv | 257 +++++++++++++++++++++++++
 tb/tb_ctrl_unit_mc.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit_mc.sv
// rtl/ctrl_unit_mc.sv - multicycle Moore control FSM for the datapath select/enable buses
// Optional feature macro: OVERFLOW_TRAP_EN (overflow exception path through EXCEPT)
module ctrl_unit_mc #(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       overflow,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_wr,
   output logic       ir_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_source,
   output logic       epc_write,
   output logic [3:0] state_out
);

   typedef enum logic [3:0] {
      S_RST      = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_R_EXEC   = 4'd3,
      S_R_WB     = 4'd4,
      S_ADDI_EX  = 4'd5,
      S_ADDI_WB  = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_RD   = 4'd8,
      S_LW_WB    = 4'd9,
      S_MEM_WR   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_EXCEPT   = 4'd13
   } state_t;

   localparam logic [2:0] OP_IDLE = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_OFFS  = 2'b10;
   localparam logic [1:0] SRCB_IMM   = 2'b11;

   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_OUT  = 2'b01;
   localparam logic [1:0] PCSRC_JMP  = 2'b10;
   localparam logic [1:0] PCSRC_EXC  = 2'b11;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] rop_q, rop_d;
   logic [2:0] funct_op;
   logic       wait_state;
   logic       wait_last;

   // The ALU flags only matter to the trap path; zero is consumed by the datapath via pc_write_cond.
`ifdef OVERFLOW_TRAP_EN
   logic unused_inputs;
   assign unused_inputs = zero;
`else
   logic unused_inputs;
   assign unused_inputs = zero ^ overflow;
`endif

   // R-type function decode; unsupported functs map to idle and abort the instruction.
   always_comb begin
      funct_op = OP_IDLE;
      case (funct)
         6'h20:   funct_op = OP_ADD;
         6'h22:   funct_op = OP_SUB;
         6'h24:   funct_op = OP_AND;
         6'h25:   funct_op = OP_OR;
         default: funct_op = OP_IDLE;
      endcase
   end

   assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   assign wait_last  = (cnt_q == WAIT_LAST);

   // Wait counter runs only while holding a memory state and restarts at zero on every exit.
   always_comb begin
      cnt_d = 4'd0;
      if (wait_state && !wait_last) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // The R-type ALU op is captured during DECODE so R_EXEC outputs stay a function of registers only.
   always_comb begin
      rop_d = rop_q;
      if (state_q == S_DECODE) begin
         rop_d = funct_op;
      end
   end

   // State, wait counter and captured ALU op registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_RST;
         cnt_q   <= 4'd0;
         rop_q   <= OP_IDLE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rop_q   <= rop_d;
      end
   end

   // Next-state sequencing: opcode dispatch in DECODE, memory-wait holds, overflow trap when enabled.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_RST:    state_d = S_FETCH;
         S_FETCH:  state_d = wait_last ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               6'h00:        state_d = S_R_EXEC;
               6'h08:        state_d = S_ADDI_EX;
               6'h23, 6'h2B: state_d = S_MEM_ADDR;
               6'h04:        state_d = S_BRANCH;
               6'h02:        state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_R_EXEC: begin
            if (rop_q == OP_IDLE) begin
               state_d = S_FETCH;
            end
`ifdef OVERFLOW_TRAP_EN
            else if (overflow && ((rop_q == OP_ADD) || (rop_q == OP_SUB))) begin
               state_d = S_EXCEPT;
            end
`endif
            else begin
               state_d = S_R_WB;
            end
         end
         S_R_WB:   state_d = S_FETCH;
         S_ADDI_EX: begin
`ifdef OVERFLOW_TRAP_EN
            state_d = overflow ? S_EXCEPT : S_ADDI_WB;
`else
            state_d = S_ADDI_WB;
`endif
         end
         S_ADDI_WB:  state_d = S_FETCH;
         S_MEM_ADDR: state_d = (opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   state_d = wait_last ? S_LW_WB : S_MEM_RD;
         S_LW_WB:    state_d = S_FETCH;
         S_MEM_WR:   state_d = wait_last ? S_FETCH : S_MEM_WR;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
`ifdef OVERFLOW_TRAP_EN
         S_EXCEPT:   state_d = S_FETCH;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   // Moore output decode from state register, wait counter and captured ALU op.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_wr        = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = OP_IDLE;
      pc_source     = PCSRC_ALU;
      epc_write     = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_b = SRCB_FOUR;
            alu_op    = OP_ADD;
            ir_write  = wait_last;
            pc_write  = wait_last;
         end
         S_DECODE: begin
            alu_src_b = SRCB_OFFS;
            alu_op    = OP_ADD;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            alu_op    = rop_q;
         end
         S_R_WB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         S_ADDI_EX, S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = OP_ADD;
         end
         S_ADDI_WB: begin
            reg_write = 1'b1;
         end
         S_MEM_RD: begin
            i_or_d = 1'b1;
         end
         S_LW_WB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         S_MEM_WR: begin
            i_or_d = 1'b1;
            mem_wr = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRCB_B;
            alu_op        = OP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_OUT;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JMP;
         end
`ifdef OVERFLOW_TRAP_EN
         // EPC <= PC - 4 while the PC is redirected to the exception vector.
         S_EXCEPT: begin
            epc_write = 1'b1;
            pc_write  = 1'b1;
            pc_source = PCSRC_EXC;
            alu_src_b = SRCB_FOUR;
            alu_op    = OP_SUB;
         end
`endif
         default: begin
            pc_write = 1'b0;
         end
      endcase
   end

   assign state_out = state_q;

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// tb/tb_ctrl_unit_mc.sv - self-checking bench for ctrl_unit_mc
module tb_ctrl_unit_mc;

   localparam int MW = 1;
`ifdef OVERFLOW_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   localparam int DC = -1;
   localparam int ADD = 1, SUB = 2, AND_ = 3, OR_ = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] opcode = 6'h0;
   logic [5:0] funct = 6'h0;
   logic       zero = 1'b0;
   logic       overflow = 1'b0;
   logic       pc_write, pc_write_cond, i_or_d, mem_wr, ir_write, reg_write;
   logic       reg_dst, mem_to_reg, alu_src_a, epc_write;
   logic [1:0] alu_src_b, pc_source;
   logic [2:0] alu_op;
   logic [3:0] state_out;

   ctrl_unit_mc #(.MEM_WAIT(MW)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
      .zero(zero), .overflow(overflow),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_wr(mem_wr), .ir_write(ir_write), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
      .epc_write(epc_write), .state_out(state_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, pcwc, iord, memwr, irw, regw, regdst, m2r, srca;
      logic [1:0] srcb;
      logic [2:0] aop;
      logic [1:0] pcsrc;
      logic       epcw;
   } outs_t;

   typedef struct {
      outs_t v;
      outs_t m;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   memwr_seen = 0;

   // One expected cycle; DC marks a select the specification leaves open in that state.
   function automatic exp_t mk(int st, int pcw, int pcwc, int iord, int memwr, int irw,
                               int regw, int regdst, int m2r, int srca, int srcb,
                               int aop, int pcsrc, int epcw);
      exp_t e;
      e.v = '0;
      e.m = '0;
      e.v.st = st[3:0];      e.m.st = '1;
      e.v.pcw = pcw[0];      e.m.pcw = 1'b1;
      e.v.pcwc = pcwc[0];    e.m.pcwc = 1'b1;
      e.v.memwr = memwr[0];  e.m.memwr = 1'b1;
      e.v.irw = irw[0];      e.m.irw = 1'b1;
      e.v.regw = regw[0];    e.m.regw = 1'b1;
      e.v.epcw = epcw[0];    e.m.epcw = 1'b1;
      if (iord >= 0)   begin e.v.iord = iord[0];     e.m.iord = 1'b1;  end
      if (regdst >= 0) begin e.v.regdst = regdst[0]; e.m.regdst = 1'b1; end
      if (m2r >= 0)    begin e.v.m2r = m2r[0];       e.m.m2r = 1'b1;   end
      if (srca >= 0)   begin e.v.srca = srca[0];     e.m.srca = 1'b1;  end
      if (srcb >= 0)   begin e.v.srcb = srcb[1:0];   e.m.srcb = '1;    end
      if (aop >= 0)    begin e.v.aop = aop[2:0];     e.m.aop = '1;     end
      if (pcsrc >= 0)  begin e.v.pcsrc = pcsrc[1:0]; e.m.pcsrc = '1;   end
      return e;
   endfunction

   function automatic exp_t rst_cycle();
      exp_t e;
      e.v = '0;
      e.m = '1;
      return e;
   endfunction

   function automatic exp_t except_cycle();
      return mk(13, 1, 0, DC, 0, 0, 0, DC, DC, 0, 1, SUB, 3, 1);
   endfunction

   // Instruction-level model: the cycle-by-cycle output trace one instruction must produce.
   task automatic push_instr(input int op, input int fn, input bit ov);
      int rop;
      for (int i = 0; i <= MW; i++) begin
         int last = (i == MW) ? 1 : 0;
         q.push_back(mk(1, last, 0, 0, 0, last, 0, DC, DC, 0, 1, ADD, 0, 0));
      end
      q.push_back(mk(2, 0, 0, DC, 0, 0, 0, DC, DC, 0, 2, ADD, DC, 0));
      case (op)
         'h00: begin
            case (fn)
               'h20: rop = ADD;
               'h22: rop = SUB;
               'h24: rop = AND_;
               'h25: rop = OR_;
               default: rop = 0;
            endcase
            q.push_back(mk(3, 0, 0, DC, 0, 0, 0, DC, DC, 1, 0, (rop == 0) ? DC : rop, DC, 0));
            if (rop != 0) begin
               if (TRAP && ov && (rop == ADD || rop == SUB)) q.push_back(except_cycle());
               else q.push_back(mk(4, 0, 0, DC, 0, 0, 1, 1, 0, DC, DC, DC, DC, 0));
            end
         end
         'h08: begin
            q.push_back(mk(5, 0, 0, DC, 0, 0, 0, DC, DC, 1, 3, ADD, DC, 0));
            if (TRAP && ov) q.push_back(except_cycle());
            else q.push_back(mk(6, 0, 0, DC, 0, 0, 1, 0, 0, DC, DC, DC, DC, 0));
         end
         'h23, 'h2B: begin
            q.push_back(mk(7, 0, 0, DC, 0, 0, 0, DC, DC, 1, 3, ADD, DC, 0));
            for (int i = 0; i <= MW; i++) begin
               if (op == 'h23) q.push_back(mk(8, 0, 0, 1, 0, 0, 0, DC, DC, DC, DC, DC, DC, 0));
               else q.push_back(mk(10, 0, 0, 1, 1, 0, 0, DC, DC, DC, DC, DC, DC, 0));
            end
            if (op == 'h23) q.push_back(mk(9, 0, 0, DC, 0, 0, 1, 0, 1, DC, DC, DC, DC, 0));
         end
         'h04: q.push_back(mk(11, 0, 1, DC, 0, 0, 0, DC, DC, 1, 0, SUB, 1, 0));
         'h02: q.push_back(mk(12, 1, 0, DC, 0, 0, 0, DC, DC, DC, DC, DC, 2, 0));
         default: ;
      endcase
   endtask

   // Compare process: every cycle with a pending expectation is checked mid-cycle.
   always @(negedge clk) begin
      outs_t got;
      exp_t  e;
      cyc++;
      if (mem_wr === 1'b1) memwr_seen++;
      if (q.size() > 0) begin
         e = q.pop_front();
         got = {state_out, pc_write, pc_write_cond, i_or_d, mem_wr, ir_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, epc_write};
         checks++;
         if (((got ^ e.v) & e.m) !== '0) begin
            errors++;
            $display("FAIL outputs cyc=%0d state want %0d: got %h required %h (mask %h)",
                     cyc, e.v.st, got, e.v, e.m);
         end
      end
   end

   task automatic wait_drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending required 0", q.size());
         q.delete();
      end
   endtask

   task automatic run(input int op, input int fn, input bit ov, input bit z);
      opcode = op[5:0];
      funct = fn[5:0];
      overflow = ov;
      zero = z;
      push_instr(op, fn, ov);
      wait_drain();
   endtask

   task automatic lit(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, want);
      end
   endtask

   initial begin
      int lw_st[7];
      int r_st[5];
      int r_srcb[4];
      lw_st = '{1, 1, 2, 7, 8, 8, 9};
      r_st = '{1, 1, 2, 3, 4};
      r_srcb = '{1, 1, 2, 0};

      reset_n = 1'b0;
      @(posedge clk); #1;
      q.push_back(rst_cycle());
      @(posedge clk); #1;
      q.push_back(rst_cycle());
      reset_n = 1'b1;
      wait_drain();

      // Pin the model itself against hand-derived traces before using it.
      push_instr('h00, 'h20, 1'b0);
      lit("model_r_len", q.size(), 5);
      for (int i = 0; i < 5; i++) lit("model_r_state", int'(q[i].v.st), r_st[i]);
      for (int i = 0; i < 4; i++) lit("model_r_srcb", int'(q[i].v.srcb), r_srcb[i]);
      lit("model_r_wb_regdst", int'(q[4].v.regdst), 1);
      q.delete();
      push_instr('h23, 0, 1'b0);
      lit("model_lw_len", q.size(), 7);
      for (int i = 0; i < 7; i++) lit("model_lw_state", int'(q[i].v.st), lw_st[i]);
      q.delete();

      run('h00, 'h20, 1'b0, 1'b0);
      run('h00, 'h22, 1'b0, 1'b1);
      run('h00, 'h24, 1'b1, 1'b0);
      run('h00, 'h25, 1'b1, 1'b0);
      run('h00, 'h3F, 1'b0, 1'b0);
      run('h00, 'h20, 1'b1, 1'b0);
      run('h08, 0, 1'b0, 1'b0);
      run('h08, 0, 1'b1, 1'b0);
      run('h23, 0, 1'b0, 1'b0);
      memwr_seen = 0;
      run('h2B, 0, 1'b0, 1'b0);
      lit("sw_mem_wr_cycles", memwr_seen, 2);
      run('h04, 0, 1'b0, 1'b1);
      run('h04, 0, 1'b0, 1'b0);
      run('h02, 0, 1'b0, 1'b0);
      run('h3F, 0, 1'b0, 1'b0);

      // Reset asserted during the first MEM_WR cycle.
      opcode = 6'h2B;
      funct = 6'h0;
      overflow = 1'b0;
      push_instr('h2B, 0, 1'b0);
      while (q.size() > MW + 4) void'(q.pop_back());
      repeat (MW + 3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      q.push_back(rst_cycle());
      @(posedge clk); #1;
      reset_n = 1'b1;
      wait_drain();
      run('h00, 'h25, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
